// File: rtl/branch_ctrl_pkg.sv
// Shared widths, controller state encodings and the register-hit helper
// used by the ID-stage branch sequencing logic.
package branch_ctrl_pkg;

    localparam int W_ADDR = 32;
    localparam int W_REG  = 5;

    localparam logic [1:0] BRC_IDLE = 2'd0;
    localparam logic [1:0] BRC_WAIT = 2'd1;
    localparam logic [1:0] BRC_HOLD = 2'd2;

    typedef struct packed {
        logic             wen;
        logic             load;
        logic [W_REG-1:0] wreg;
    } wb_src_t;

    // $0 is hardwired, so a write to it can never create a dependency.
    function automatic logic reg_hit(input wb_src_t src,
                                     input logic [W_REG-1:0] rs,
                                     input logic [W_REG-1:0] rt,
                                     input logic rt_used);
        return src.wen && (src.wreg != '0) &&
               ((src.wreg == rs) || (rt_used && (src.wreg == rt)));
    endfunction

endpackage

// File: rtl/branch_hazard.sv
// Operand-readiness check for an ID-stage consumer: returns how many cycles
// it must wait before EX/MEM results become forwardable.
module branch_hazard
    import branch_ctrl_pkg::*;
(
    input  logic [W_REG-1:0] rs_i,
    input  logic [W_REG-1:0] rt_i,
    input  logic             rt_used_i,
    input  wb_src_t          ex_i,
    input  wb_src_t          mem_i,
    output logic [1:0]       wait_cnt_o
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = reg_hit(ex_i,  rs_i, rt_i, rt_used_i);
    assign mem_hit = reg_hit(mem_i, rs_i, rt_i, rt_used_i);

    // EX hits always dominate a MEM load hit, so checking EX last yields the max.
    always_comb begin
        wait_cnt_o = 2'd0;
        if (mem_hit && mem_i.load) wait_cnt_o = 2'd1;
        if (ex_hit)                wait_cnt_o = ex_i.load ? 2'd2 : 2'd1;
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: stalls on unresolved operands, issues the fetch
// redirect, holds a latched target until fetch accepts, tracks delay slots.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int STALL_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_is_br,
    input  logic [W_REG-1:0]  id_rs,
    input  logic [W_REG-1:0]  id_rt,
    input  logic              id_rt_used,
    input  logic              ex_wen,
    input  logic              ex_load,
    input  logic [W_REG-1:0]  ex_wreg,
    input  logic              mem_wen,
    input  logic              mem_load,
    input  logic [W_REG-1:0]  mem_wreg,
    input  logic              branch,
    input  logic [W_ADDR-1:0] branch_addr,
    input  logic              if_ready,
    output logic              stall_id,
    output logic              flush_ex,
    output logic              redirect_valid,
    output logic [W_ADDR-1:0] redirect_pc,
    output logic              in_delay_slot
);

    logic [1:0]        state_q, state_d;
    logic [STALL_W-1:0] cnt_q, cnt_d;
    logic [W_ADDR-1:0] tgt_q, tgt_d;
    logic              ids_q, ids_d;

    logic [1:0]        wait_cnt;
    logic              resolve;
    logic              stall_c, fx_c, rv_c;
    logic [W_ADDR-1:0] rpc_c;

    branch_hazard u_hazard (
        .rs_i       (id_rs),
        .rt_i       (id_rt),
        .rt_used_i  (id_rt_used),
        .ex_i       ('{wen: ex_wen,  load: ex_load,  wreg: ex_wreg}),
        .mem_i      ('{wen: mem_wen, load: mem_load, wreg: mem_wreg}),
        .wait_cnt_o (wait_cnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        ids_d   = ids_q;
        resolve = 1'b0;
        stall_c = 1'b0;
        fx_c    = 1'b0;
        rv_c    = 1'b0;
        rpc_c   = '0;

        case (state_q)
            BRC_IDLE: begin
                if (id_valid && id_is_br) begin
                    if (wait_cnt != 2'd0) begin
                        cnt_d   = STALL_W'(wait_cnt - 2'd1);
                        stall_c = 1'b1;
                        fx_c    = 1'b1;
                        state_d = BRC_WAIT;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            BRC_WAIT: begin
                // Operands are forwardable once the counter drains; no re-check.
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - STALL_W'(1);
                    stall_c = 1'b1;
                    fx_c    = 1'b1;
                end else begin
                    resolve = 1'b1;
                end
            end
            BRC_HOLD: begin
                rv_c  = 1'b1;
                rpc_c = tgt_q;
                if (if_ready) begin
                    state_d = BRC_IDLE;
                end else begin
                    stall_c = 1'b1;
                    fx_c    = 1'b1;
                end
            end
            default: state_d = BRC_IDLE;
        endcase

        if (resolve) begin
            state_d = BRC_IDLE;
            if (branch) begin
                rv_c  = 1'b1;
                rpc_c = branch_addr;
                if (!if_ready) begin
                    tgt_d   = branch_addr;
                    stall_c = 1'b1;
                    fx_c    = 1'b1;
                    state_d = BRC_HOLD;
                end
            end
        end

        // Whatever leaves ID next decides the delay-slot flag.
        if (id_valid && !stall_c) ids_d = id_is_br;

        if (flush) begin
            state_d = BRC_IDLE;
            cnt_d   = '0;
            tgt_d   = '0;
            ids_d   = 1'b0;
            stall_c = 1'b0;
            fx_c    = 1'b0;
            rv_c    = 1'b0;
            rpc_c   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BRC_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            ids_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            ids_q   <= ids_d;
        end
    end

    // Outputs are quiet while reset is held, even if ID shows a live branch.
    assign stall_id       = rst_n & stall_c;
    assign flush_ex       = rst_n & fx_c;
    assign redirect_valid = rst_n & rv_c;
    assign redirect_pc    = rst_n ? rpc_c : '0;
    assign in_delay_slot  = ids_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: transaction-level model of stall,
// redirect and delay-slot behaviour, directed cases plus random branches.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, id_valid, id_is_br, id_rt_used;
    logic [4:0]  id_rs, id_rt, ex_wreg, mem_wreg;
    logic        ex_wen, ex_load, mem_wen, mem_load;
    logic        branch, if_ready;
    logic [31:0] branch_addr;
    logic        stall_id, flush_ex, redirect_valid, in_delay_slot;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;
    logic m_ids = 1'b0;

    always #5 clk = ~clk;

    branch_ctrl #(.STALL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_is_br(id_is_br),
        .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .ex_wen(ex_wen), .ex_load(ex_load), .ex_wreg(ex_wreg),
        .mem_wen(mem_wen), .mem_load(mem_load), .mem_wreg(mem_wreg),
        .branch(branch), .branch_addr(branch_addr), .if_ready(if_ready),
        .stall_id(stall_id), .flush_ex(flush_ex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .in_delay_slot(in_delay_slot)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int hits(input logic wen, input logic [4:0] wreg);
        return (wen && wreg != 0 && (wreg == id_rs || (id_rt_used && wreg == id_rt))) ? 1 : 0;
    endfunction

    // Cycles the branch must wait: the worst of the producing stages.
    function automatic int model_wait();
        int e = 0;
        int m = 0;
        if (hits(ex_wen, ex_wreg) != 0) e = ex_load ? 2 : 1;
        if (hits(mem_wen, mem_wreg) != 0 && mem_load) m = 1;
        return (e > m) ? e : m;
    endfunction

    // Check one cycle's outputs at the falling edge, then advance the clock.
    task automatic cyc(input string tag, input logic es, input logic efx,
                       input logic erv, input logic [31:0] epc, input logic chk_fx);
        @(negedge clk);
        chk({tag, ".stall"}, {31'd0, stall_id}, {31'd0, es});
        if (chk_fx) chk({tag, ".flush_ex"}, {31'd0, flush_ex}, {31'd0, efx});
        chk({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, erv});
        if (erv) chk({tag, ".pc"}, redirect_pc, epc);
        chk({tag, ".ids"}, {31'd0, in_delay_slot}, {31'd0, m_ids});
        if (flush) m_ids = 1'b0;
        else if (id_valid && !es) m_ids = id_is_br;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_hz();
        ex_wen = 0; ex_load = 0; ex_wreg = 0;
        mem_wen = 0; mem_load = 0; mem_wreg = 0;
    endtask

    task automatic rnd_hz();
        id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
        id_rt_used = 1'($urandom);
        ex_wen = 1'($urandom); ex_load = 1'($urandom); ex_wreg = 5'($urandom_range(0, 7));
        mem_wen = 1'($urandom); mem_load = 1'($urandom); mem_wreg = 5'($urandom_range(0, 7));
    endtask

    // One branch through ID: wait stalls, resolve, fetch-busy hold, then a delay slot.
    task automatic do_branch(input string tag, input logic taken,
                             input logic [31:0] addr, input int busy);
        int w;
        w = model_wait();
        id_valid = 1; id_is_br = 1; flush = 0;
        for (int k = 0; k < w; k++) begin
            branch = 1'($urandom); branch_addr = $urandom; if_ready = 1'($urandom);
            cyc({tag, ".wait"}, 1, 1, 0, 0, 1);
            rnd_hz();
        end
        branch = taken; branch_addr = addr;
        if (!taken) begin
            if_ready = 1'($urandom);
            cyc({tag, ".nt"}, 0, 0, 0, 0, 1);
        end else if (busy == 0) begin
            if_ready = 1;
            cyc({tag, ".rdir"}, 0, 0, 1, addr, 1);
        end else begin
            if_ready = 0;
            cyc({tag, ".busy0"}, 1, 1, 1, addr, 1);
            for (int k = 1; k < busy; k++) begin
                branch = 1'($urandom); branch_addr = $urandom;
                cyc({tag, ".hold"}, 1, 1, 1, addr, 1);
            end
            if_ready = 1; branch_addr = ~addr;
            cyc({tag, ".accept"}, 0, 0, 1, addr, 1);
        end
        id_is_br = 0; id_valid = 1; branch = 1'($urandom); if_ready = 1'($urandom);
        cyc({tag, ".slot"}, 0, 0, 0, 0, 1);
    endtask

    task automatic idle_cyc(input string tag);
        id_is_br = 0; id_valid = 1'($urandom); rnd_hz();
        branch = 1'($urandom); branch_addr = $urandom; if_ready = 1'($urandom);
        cyc(tag, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 0; flush = 0;
        id_valid = 1; id_is_br = 1; id_rs = 1; id_rt = 2; id_rt_used = 1;
        clr_hz(); branch = 1; branch_addr = 32'h00400100; if_ready = 1;
        #3;
        chk("rst.stall", {31'd0, stall_id}, 32'd0);
        chk("rst.fx", {31'd0, flush_ex}, 32'd0);
        chk("rst.rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst.pc", redirect_pc, 32'd0);
        chk("rst.ids", {31'd0, in_delay_slot}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;

        do_branch("nodep", 1, 32'h00400100, 0);

        clr_hz(); ex_wen = 1; ex_load = 1; ex_wreg = 5; id_rs = 5; id_rt = 6; id_rt_used = 0;
        do_branch("exld", 1, 32'h00400200, 0);

        clr_hz(); mem_wen = 1; mem_load = 1; mem_wreg = 7; id_rs = 3; id_rt = 7; id_rt_used = 0;
        do_branch("memrt_nouse", 1, 32'h00400300, 0);
        clr_hz(); mem_wen = 1; mem_load = 1; mem_wreg = 7; id_rs = 3; id_rt = 7; id_rt_used = 1;
        do_branch("memrt_use", 1, 32'h00400340, 0);
        clr_hz(); ex_wen = 1; ex_load = 1; ex_wreg = 0; mem_wen = 1; mem_load = 1; mem_wreg = 0;
        id_rs = 0; id_rt = 0; id_rt_used = 1;
        do_branch("zero_reg", 1, 32'h00400380, 0);

        clr_hz(); id_rs = 1; id_rt = 2;
        do_branch("fetch_busy", 1, 32'h00400400, 3);

        // Flush in WAIT with counter at 1; a preceding not-taken branch sets the slot flag.
        clr_hz(); id_valid = 1; id_is_br = 1; branch = 0; if_ready = 1;
        cyc("fw.pre", 0, 0, 0, 0, 1);
        ex_wen = 1; ex_load = 1; ex_wreg = 5; id_rs = 5; branch = 1; branch_addr = 32'h00400500;
        cyc("fw.s0", 1, 1, 0, 0, 1);
        flush = 1;
        cyc("fw.flush", 0, 0, 0, 0, 0);
        flush = 0; id_valid = 0; id_is_br = 0;
        cyc("fw.post", 0, 0, 0, 0, 1);

        // Flush in HOLD.
        clr_hz(); id_valid = 1; id_is_br = 1; branch = 0; if_ready = 1;
        cyc("fh.pre", 0, 0, 0, 0, 1);
        branch = 1; branch_addr = 32'h00400600; if_ready = 0;
        cyc("fh.res", 1, 1, 1, 32'h00400600, 1);
        branch_addr = 32'h12345678;
        cyc("fh.hold", 1, 1, 1, 32'h00400600, 1);
        flush = 1;
        cyc("fh.flush", 0, 0, 0, 0, 0);
        flush = 0; id_valid = 0; id_is_br = 0; if_ready = 1;
        cyc("fh.post", 0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of HOLD.
        clr_hz(); id_valid = 1; id_is_br = 1; branch = 1; branch_addr = 32'h00400700; if_ready = 0;
        cyc("rh.res", 1, 1, 1, 32'h00400700, 1);
        #2 rst_n = 0;
        #1;
        chk("rh.stall", {31'd0, stall_id}, 32'd0);
        chk("rh.fx", {31'd0, flush_ex}, 32'd0);
        chk("rh.rv", {31'd0, redirect_valid}, 32'd0);
        chk("rh.pc", redirect_pc, 32'd0);
        m_ids = 1'b0;
        @(posedge clk); #1;
        rst_n = 1; id_valid = 0; id_is_br = 0; if_ready = 1;
        cyc("rh.idle", 0, 0, 0, 0, 1);
        clr_hz();
        do_branch("rh.after", 1, 32'h00400800, 1);

        for (int t = 0; t < 150; t++) begin
            rnd_hz();
            do_branch("rnd", 1'($urandom), $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle_cyc("rnd.idle");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
